matrix_in_loader: RTL
=====================

Name: matrix_in_loader

Overview:
- Upstream feeder for the DAC-side matrix stage. It replaces the debug-probe writes into the eight 64-deep x 256-bit input RAMs.
- Accepts a serial stream of 10-bit samples over a valid/ready handshake.
- Packs 25 samples into each 256-bit word.
- Writes the words sequentially into RAM1..RAM8 through the per-RAM write-enable / address / data bus that the DAC top consumes.

Parameters:
- SAMP_W, 10, sample width in bits.
- LANES, 25, samples per 256-bit word (LANES*SAMP_W must be at most 256).
- NUM_RAM, 8, number of input RAMs.
- ADR_W, 6, RAM address width (depth 64).

Ports:
- clk_250MHz  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle pulse that starts a load.
- n_words  in  7  words per RAM, 1..64. 0 means start is ignored; values above 64 are clamped to 64. Sampled on the accepted start.
- s_valid  in  1  sample valid.
- s_ready  out  1  sample ready.
- s_dat  in  SAMP_W  sample data.
- ram_wen  out  NUM_RAM  one-hot write enable; bit i drives in_ram(i+1)_wen.
- ram_wadrs  out  ADR_W  write address, shared by all RAMs.
- ram_wdat  out  256  write data, shared by all RAMs.
- busy  out  1  high while in LOAD or FLUSH.
- done  out  1  one-cycle pulse when a load completes.
- STATE  out  2  FSM state encoding: 0 IDLE, 1 LOAD, 2 FLUSH, 3 DONE.

Behaviour:
- Reset values: s_ready=0, ram_wen=0, ram_wadrs=0, ram_wdat=0, busy=0, done=0, STATE=IDLE. All internal counters and the pack register clear to 0.
- Reset mid-operation: on the next edge the block returns to the full reset state. No write issues in that cycle, and any partial word is discarded.
- IDLE:
  - s_ready=0.
  - start=1 with n_words != 0: latch nw = min(n_words, 64), clear lane, addr and sel, go to LOAD.
  - start=1 with n_words == 0: ignored.
- LOAD:
  - s_ready=1.
  - Handshake: a sample is accepted when s_valid and s_ready are both high in the same cycle.
  - The accepted sample is written into pack bits [10*lane+9 : 10*lane]; lane then increments.
  - When the sample accepted is lane 24:
    - Next cycle: ram_wen = one-hot(sel), ram_wadrs = addr, ram_wdat = {6'b0, pack with lane 24 included}. Write latency is exactly 1 cycle after the 25th handshake.
    - lane resets to 0 and the pack register clears.
    - If addr == nw-1: addr=0 and sel increments. Otherwise addr increments.
  - If that word is the last one (sel==7 and addr==nw-1): s_ready drops in the same cycle as the final handshake (registered, so no extra sample is accepted) and the FSM goes to FLUSH.
- Write pulse rules:
  - ram_wen is high for one cycle per word and is otherwise 0.
  - ram_wadrs and ram_wdat hold their last value when ram_wen=0.
  - Back-to-back words are possible only after 25 samples, so two writes never occur in consecutive cycles.
- FLUSH: the final write is on the bus this cycle; go to DONE.
- DONE: done=1 for one cycle, busy=0, then IDLE.
- start while busy (LOAD or FLUSH) or in DONE: ignored. n_words changes after start have no effect.
- Samples per load: exactly 25 * nw * 8. Upper bits [255:250] of every word are always 0.
- s_valid gaps: no effect on packing order. lane holds while s_valid=0.

Test Plan:
- Minimal load: n_words=1, start, stream s_dat = 0..199 without gaps.
  - Required: 8 writes with ram_wen = 0x01, 0x02, ..., 0x80, all at ram_wadrs=0.
  - Write k carries lanes = 25k..25k+24, so word0 bits[9:0]=0 and bits[249:240]=24.
  - done pulses 2 cycles after the 200th handshake. s_ready=0 after the 200th handshake.
- Full depth: n_words=64, 12800 samples.
  - Required: each RAM receives addresses 0..63 in order, 512 writes total, exactly one done.
  - n_words=100 behaves identically (clamped to 64).
- Backpressure: n_words=2, s_valid toggled 1-0-1-0.
  - Required: same ram_wdat as the gapless run.
  - Each write occurs 1 cycle after the 25th accepted sample.
  - No write occurs in a cycle without a preceding 25th handshake.
- Ignored starts:
  - n_words=0 with start: STATE stays 0, s_ready stays 0.
  - A start pulse mid-LOAD leaves the counters unchanged and the write sequence intact.
- Reset mid-load: n_words=1, assert rst after 60 samples.
  - Required: next cycle all outputs are at reset values and no write issues.
  - A new start with 200 samples then reproduces the minimal-load sequence exactly, so no partial word leaks.

Source files
------------

// File: rtl/matrix_in_loader.sv
// matrix_in_loader: packs a serial stream of samples into wide words and
// writes them sequentially into the DAC-side input RAMs (RAM1..RAM8).
module matrix_in_loader #(
  parameter int unsigned SAMP_W  = 10,
  parameter int unsigned LANES   = 25,
  parameter int unsigned NUM_RAM = 8,
  parameter int unsigned ADR_W   = 6
) (
  input  logic                   clk_250MHz,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ADR_W:0]         n_words,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [SAMP_W-1:0]      s_dat,
  output logic [NUM_RAM-1:0]     ram_wen,
  output logic [ADR_W-1:0]       ram_wadrs,
  output logic [255:0]           ram_wdat,
  output logic                   busy,
  output logic                   done,
  output logic [1:0]             STATE
);

  localparam int unsigned WORD_W = 256;
  localparam int unsigned PACK_W = LANES * SAMP_W;
  localparam int unsigned LANE_W = $clog2(LANES);
  localparam int unsigned SEL_W  = $clog2(NUM_RAM);
  localparam int unsigned NW_W   = ADR_W + 1;
  localparam int unsigned DEPTH  = 1 << ADR_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [LANE_W-1:0]   lane_q, lane_d;
  logic [ADR_W-1:0]    addr_q, addr_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [NW_W-1:0]     nw_q, nw_d;
  logic [PACK_W-1:0]   pack_q, pack_d;
  logic [PACK_W-1:0]   pack_ins;
  logic                s_ready_q, s_ready_d;
  logic [NUM_RAM-1:0]  wen_q, wen_d;
  logic [ADR_W-1:0]    wadrs_q, wadrs_d;
  logic [WORD_W-1:0]   wdat_q, wdat_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                last_addr;

  assign last_addr = ({1'b0, addr_q} == (nw_q - NW_W'(1)));

  // State register and all registered outputs
  always_ff @(posedge clk_250MHz) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      lane_q    <= '0;
      addr_q    <= '0;
      sel_q     <= '0;
      nw_q      <= '0;
      pack_q    <= '0;
      s_ready_q <= 1'b0;
      wen_q     <= '0;
      wadrs_q   <= '0;
      wdat_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lane_q    <= lane_d;
      addr_q    <= addr_d;
      sel_q     <= sel_d;
      nw_q      <= nw_d;
      pack_q    <= pack_d;
      s_ready_q <= s_ready_d;
      wen_q     <= wen_d;
      wadrs_q   <= wadrs_d;
      wdat_q    <= wdat_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next-state, packing and write-bus generation
  always_comb begin
    state_d  = state_q;
    lane_d   = lane_q;
    addr_d   = addr_q;
    sel_d    = sel_q;
    nw_d     = nw_q;
    pack_d   = pack_q;
    pack_ins = pack_q;
    wen_d    = '0;
    wadrs_d  = wadrs_q;
    wdat_d   = wdat_q;

    case (state_q)
      ST_IDLE: begin
        if (start && (n_words != '0)) begin
          nw_d    = (n_words > NW_W'(DEPTH)) ? NW_W'(DEPTH) : n_words;
          lane_d  = '0;
          addr_d  = '0;
          sel_d   = '0;
          pack_d  = '0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (s_valid && s_ready_q) begin
          pack_ins[lane_q*SAMP_W +: SAMP_W] = s_dat;
          if (lane_q == LANE_W'(LANES - 1)) begin
            // Word complete: present it on the write bus next cycle
            wen_d   = NUM_RAM'(1) << sel_q;
            wadrs_d = addr_q;
            wdat_d  = WORD_W'(pack_ins);
            lane_d  = '0;
            pack_d  = '0;
            if (last_addr) begin
              addr_d = '0;
              sel_d  = sel_q + SEL_W'(1);
              if (sel_q == SEL_W'(NUM_RAM - 1)) begin
                state_d = ST_FLUSH;
              end
            end else begin
              addr_d = addr_q + ADR_W'(1);
            end
          end else begin
            lane_d = lane_q + LANE_W'(1);
            pack_d = pack_ins;
          end
        end
      end
      ST_FLUSH: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // Status outputs follow the state being entered so they register in step
    s_ready_d = (state_d == ST_LOAD);
    busy_d    = (state_d == ST_LOAD) || (state_d == ST_FLUSH);
    done_d    = (state_d == ST_DONE);
  end

  assign s_ready   = s_ready_q;
  assign ram_wen   = wen_q;
  assign ram_wadrs = wadrs_q;
  assign ram_wdat  = wdat_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign STATE     = state_q;

endmodule
